// File: rtl/fifo_lockstep_reader.sv
// Read-side consumer for a lockstep-written redundant FIFO pair.
// Pops both FIFOs with one common rd_en, compares the two head words on
// every pop, and forwards the FIFO1 word through a registered valid/ready
// stage. Detects data mismatches and valid skew, and can halt on fault.
//
// Ports:
//   clk, rst_n              clock (posedge), synchronous active-low reset
//   en                      enable reading (IDLE <-> RUN)
//   err_clr                 clear error flags and skew counter, release HALT
//   rd_valid_1/rd_data_1    FIFO1 first-word-fall-through head
//   rd_valid_2/rd_data_2    FIFO2 first-word-fall-through head
//   rd_en                   common pop to both FIFOs (combinational)
//   out_valid/out_data      registered downstream word
//   out_ready               downstream accept
//   mismatch                one-cycle pulse after a mismatching pop
//   err_sticky, skew_err    sticky fault flags
//   mismatch_cnt            saturating count of mismatching pops
//   pop_cnt                 wrapping count of pops
//   state                   0 IDLE, 1 RUN, 2 HALT
module fifo_lockstep_reader #(
  parameter int unsigned DATA_WIDTH       = 8,
  parameter int unsigned CNT_WIDTH        = 8,
  parameter int unsigned SKEW_MAX         = 3,
  parameter int unsigned HALT_ON_MISMATCH = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  err_clr,
  input  logic                  rd_valid_1,
  input  logic [DATA_WIDTH-1:0] rd_data_1,
  input  logic                  rd_valid_2,
  input  logic [DATA_WIDTH-1:0] rd_data_2,
  output logic                  rd_en,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic                  mismatch,
  output logic                  err_sticky,
  output logic                  skew_err,
  output logic [CNT_WIDTH-1:0]  mismatch_cnt,
  output logic [CNT_WIDTH-1:0]  pop_cnt,
  output logic [1:0]            state
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StHalt = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  mismatch_q, mismatch_d;
  logic                  err_sticky_q, err_sticky_d;
  logic                  skew_err_q, skew_err_d;
  logic [CNT_WIDTH-1:0]  mismatch_cnt_q, mismatch_cnt_d;
  logic [CNT_WIDTH-1:0]  pop_cnt_q, pop_cnt_d;
  logic [3:0]            skew_cnt_q, skew_cnt_d;

  logic run;
  logic pop;
  logic data_mm;
  logic skew_now;
  logic skew_fault;

  assign run      = (state_q == StRun);
  assign pop      = run && rd_valid_1 && rd_valid_2 && (!out_valid_q || out_ready);
  assign data_mm  = pop && (rd_data_1 != rd_data_2);
  assign skew_now = (rd_valid_1 != rd_valid_2);
  // Fault fires on the cycle whose increment would bring the counter to SKEW_MAX.
  assign skew_fault = run && skew_now && (({1'b0, skew_cnt_q} + 5'd1) >= 5'(SKEW_MAX));

  always_comb begin
    state_d        = state_q;
    out_valid_d    = out_valid_q;
    out_data_d     = out_data_q;
    mismatch_d     = data_mm;
    err_sticky_d   = err_sticky_q;
    skew_err_d     = skew_err_q;
    mismatch_cnt_d = mismatch_cnt_q;
    pop_cnt_d      = pop_cnt_q;
    skew_cnt_d     = skew_cnt_q;

    // Output stage: a pop refills even while the current word is being accepted.
    if (pop) begin
      out_valid_d = 1'b1;
      out_data_d  = rd_data_1;
      pop_cnt_d   = pop_cnt_q + CNT_WIDTH'(1);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    if (data_mm && (mismatch_cnt_q != {CNT_WIDTH{1'b1}})) begin
      mismatch_cnt_d = mismatch_cnt_q + CNT_WIDTH'(1);
    end

    if (err_clr) begin
      skew_cnt_d = '0;
    end else if (run) begin
      skew_cnt_d = skew_now ? skew_cnt_q + 4'd1 : 4'd0;
    end

    // A fault in the same cycle as err_clr wins.
    if (skew_fault) begin
      skew_err_d = 1'b1;
    end else if (err_clr) begin
      skew_err_d = 1'b0;
    end

    if (skew_fault || data_mm) begin
      err_sticky_d = 1'b1;
    end else if (err_clr) begin
      err_sticky_d = 1'b0;
    end

    unique case (state_q)
      StIdle: if (en) state_d = StRun;
      StRun: begin
        if (skew_fault || (data_mm && (HALT_ON_MISMATCH != 0))) begin
          state_d = StHalt;
        end else if (!en) begin
          state_d = StIdle;
        end
      end
      StHalt: if (err_clr) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      mismatch_q     <= 1'b0;
      err_sticky_q   <= 1'b0;
      skew_err_q     <= 1'b0;
      mismatch_cnt_q <= '0;
      pop_cnt_q      <= '0;
      skew_cnt_q     <= '0;
    end else begin
      state_q        <= state_d;
      out_valid_q    <= out_valid_d;
      out_data_q     <= out_data_d;
      mismatch_q     <= mismatch_d;
      err_sticky_q   <= err_sticky_d;
      skew_err_q     <= skew_err_d;
      mismatch_cnt_q <= mismatch_cnt_d;
      pop_cnt_q      <= pop_cnt_d;
      skew_cnt_q     <= skew_cnt_d;
    end
  end

  assign rd_en        = pop;
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign mismatch     = mismatch_q;
  assign err_sticky   = err_sticky_q;
  assign skew_err     = skew_err_q;
  assign mismatch_cnt = mismatch_cnt_q;
  assign pop_cnt      = pop_cnt_q;
  assign state        = state_q;

endmodule

// File: tb/tb_fifo_lockstep_reader.sv
// Bench for fifo_lockstep_reader: two instances share the input stimulus, one
// halting on mismatch and one counting through mismatches. A per-instance
// behavioural model is compared against every output on every cycle, and
// directed scenarios pin a few literal values.
module tb_fifo_lockstep_reader;

  logic       clk = 1'b0;
  logic       rst_n, en, err_clr, v1, v2, ordy;
  logic [7:0] d1, d2;

  logic       rd_en_a, ov_a, mm_a, es_a, se_a;
  logic [7:0] od_a, mc_a, pc_a;
  logic [1:0] st_a;
  logic       rd_en_b, ov_b, mm_b, es_b, se_b;
  logic [7:0] od_b, mc_b, pc_b;
  logic [1:0] st_b;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;
  bit use_q  = 1'b1;
  logic [7:0] q1[$];
  logic [7:0] q2[$];

  always #5 clk = ~clk;

  fifo_lockstep_reader #(.DATA_WIDTH(8), .CNT_WIDTH(8), .SKEW_MAX(3), .HALT_ON_MISMATCH(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .err_clr(err_clr),
    .rd_valid_1(v1), .rd_data_1(d1), .rd_valid_2(v2), .rd_data_2(d2),
    .rd_en(rd_en_a), .out_valid(ov_a), .out_data(od_a), .out_ready(ordy),
    .mismatch(mm_a), .err_sticky(es_a), .skew_err(se_a),
    .mismatch_cnt(mc_a), .pop_cnt(pc_a), .state(st_a)
  );

  fifo_lockstep_reader #(.DATA_WIDTH(8), .CNT_WIDTH(8), .SKEW_MAX(3), .HALT_ON_MISMATCH(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .err_clr(err_clr),
    .rd_valid_1(v1), .rd_data_1(d1), .rd_valid_2(v2), .rd_data_2(d2),
    .rd_en(rd_en_b), .out_valid(ov_b), .out_data(od_b), .out_ready(ordy),
    .mismatch(mm_b), .err_sticky(es_b), .skew_err(se_b),
    .mismatch_cnt(mc_b), .pop_cnt(pc_b), .state(st_b)
  );

  // Model state: st uses the external encoding 0 IDLE, 1 RUN, 2 HALT.
  typedef struct packed {
    logic [1:0] st;
    logic       ov;
    logic [7:0] od;
    logic       mm;
    logic       es;
    logic       se;
    logic [7:0] mc;
    logic [7:0] pc;
    logic [3:0] sk;
  } mdl_t;

  mdl_t ma = '0;
  mdl_t mb = '0;

  function automatic logic pred_pop(mdl_t m, logic a1, logic a2, logic rdy);
    return (m.st == 2'd1) && a1 && a2 && (!m.ov || rdy);
  endfunction

  function automatic mdl_t step(mdl_t m, bit halt, logic rst, logic e, logic clr,
                                logic a1, logic [7:0] x1, logic a2, logic [7:0] x2,
                                logic rdy);
    mdl_t n;
    bit p, bad, skf;
    int nsk;
    n = m;
    if (!rst) return '0;
    p   = pred_pop(m, a1, a2, rdy);
    bad = p && (x1 != x2);
    nsk = int'(m.sk) + 1;
    skf = (m.st == 2'd1) && (a1 != a2) && (nsk >= 3);
    if (p) begin
      n.ov = 1'b1;
      n.od = x1;
      n.pc = 8'((int'(m.pc) + 1) % 256);
    end else if (rdy) begin
      n.ov = 1'b0;
    end
    n.mm = bad;
    if (bad && m.mc < 8'd255) n.mc = m.mc + 8'd1;
    if (clr) n.sk = 4'd0;
    else if (m.st == 2'd1) n.sk = (a1 != a2) ? 4'(nsk) : 4'd0;
    if (skf) n.se = 1'b1; else if (clr) n.se = 1'b0;
    if (skf || bad) n.es = 1'b1; else if (clr) n.es = 1'b0;
    case (m.st)
      2'd0: n.st = e ? 2'd1 : 2'd0;
      2'd1: n.st = (skf || (halt && bad)) ? 2'd2 : (e ? 2'd1 : 2'd0);
      default: n.st = clr ? 2'd0 : 2'd2;
    endcase
    return n;
  endfunction

  always @(posedge clk) begin
    ma <= step(ma, 1'b1, rst_n, en, err_clr, v1, d1, v2, d2, ordy);
    mb <= step(mb, 1'b0, rst_n, en, err_clr, v1, d1, v2, d2, ordy);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_all(input string t, input mdl_t m, input logic re, input logic ov,
                         input logic [7:0] od, input logic mm, input logic es,
                         input logic se, input logic [7:0] mc, input logic [7:0] pc,
                         input logic [1:0] st);
    chk({t, ".rd_en"}, 32'(re), 32'(pred_pop(m, v1, v2, ordy)));
    chk({t, ".out_valid"}, 32'(ov), 32'(m.ov));
    chk({t, ".out_data"}, 32'(od), 32'(m.od));
    chk({t, ".mismatch"}, 32'(mm), 32'(m.mm));
    chk({t, ".err_sticky"}, 32'(es), 32'(m.es));
    chk({t, ".skew_err"}, 32'(se), 32'(m.se));
    chk({t, ".mismatch_cnt"}, 32'(mc), 32'(m.mc));
    chk({t, ".pop_cnt"}, 32'(pc), 32'(m.pc));
    chk({t, ".state"}, 32'(st), 32'(m.st));
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      cmp_all("a", ma, rd_en_a, ov_a, od_a, mm_a, es_a, se_a, mc_a, pc_a, st_a);
      cmp_all("b", mb, rd_en_b, ov_b, od_b, mm_b, es_b, se_b, mc_b, pc_b, st_b);
    end
  end

  // One clock: present queue heads, then pop where instance a pops.
  task automatic tick();
    bit p;
    if (use_q) begin
      v1 = (q1.size() > 0);
      v2 = (q2.size() > 0);
      d1 = v1 ? q1[0] : 8'h00;
      d2 = v2 ? q2[0] : 8'h00;
    end
    p = pred_pop(ma, v1, v2, ordy);
    @(posedge clk);
    #1;
    if (use_q && p) begin
      void'(q1.pop_front());
      void'(q2.pop_front());
    end
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b);
    q1.push_back(a);
    q2.push_back(b);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; err_clr = 1'b0; ordy = 1'b1;
    v1 = 1'b0; v2 = 1'b0; d1 = 8'h00; d2 = 8'h00;
    tick();
    tick();
    chk_on = 1'b1;
    rst_n = 1'b1;
    chk("reset.state", 32'(st_a), 32'd0);
    chk("reset.out_valid", 32'(ov_a), 32'd0);
    chk("reset.pop_cnt", 32'(pc_a), 32'd0);

    // Matching stream at full throughput.
    en = 1'b1;
    push(8'h11, 8'h11); push(8'h22, 8'h22); push(8'h33, 8'h33);
    repeat (4) tick();
    chk("t1.out_data", 32'(od_a), 32'h33);
    chk("t1.pop_cnt", 32'(pc_a), 32'd3);
    repeat (2) tick();

    // Back-pressure holds the word, then pops resume.
    ordy = 1'b0;
    push(8'h44, 8'h44); push(8'h55, 8'h55); push(8'h66, 8'h66);
    repeat (3) tick();
    chk("t2.out_data", 32'(od_a), 32'h44);
    chk("t2.out_valid", 32'(ov_a), 32'd1);
    chk("t2.rd_en", 32'(rd_en_a), 32'd0);
    chk("t2.pop_cnt", 32'(pc_a), 32'd4);
    ordy = 1'b1;
    repeat (4) tick();
    chk("t2.pop_cnt_end", 32'(pc_a), 32'd6);

    // Data mismatch halts instance a.
    push(8'hA5, 8'hA4);
    tick();
    chk("t3.out_data", 32'(od_a), 32'hA5);
    chk("t3.mismatch", 32'(mm_a), 32'd1);
    chk("t3.mismatch_cnt", 32'(mc_a), 32'd1);
    chk("t3.err_sticky", 32'(es_a), 32'd1);
    chk("t3.state", 32'(st_a), 32'd2);
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t3.clr_state", 32'(st_a), 32'd0);
    chk("t3.clr_sticky", 32'(es_a), 32'd0);
    chk("t3.cnt_kept", 32'(mc_a), 32'd1);

    // Valid skew of SKEW_MAX cycles faults; two cycles do not.
    use_q = 1'b0;
    v1 = 1'b0; v2 = 1'b0;
    tick();
    v1 = 1'b1;
    repeat (3) tick();
    chk("t4.skew_err", 32'(se_a), 32'd1);
    chk("t4.state", 32'(st_a), 32'd2);
    v1 = 1'b0; err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    tick();
    v1 = 1'b1;
    repeat (2) tick();
    v2 = 1'b1; d1 = 8'h5A; d2 = 8'h5A;
    repeat (2) tick();
    v1 = 1'b0; v2 = 1'b0;
    tick();
    chk("t4.no_skew_err", 32'(se_a), 32'd0);
    chk("t4.run", 32'(st_a), 32'd1);

    // 260 mismatching pops on the non-halting instance.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 260; i++) begin
      v1 = 1'b1; v2 = 1'b1;
      d1 = 8'($urandom);
      d2 = d1 ^ 8'h01;
      tick();
    end
    v1 = 1'b0; v2 = 1'b0;
    tick();
    chk("t5.mismatch_cnt_sat", 32'(mc_b), 32'hFF);
    chk("t5.pop_cnt_wrap", 32'(pc_b), 32'h04);

    // Reset while a word is stalled in the output register.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; ordy = 1'b0;
    tick();
    v1 = 1'b1; v2 = 1'b1; d1 = 8'h77; d2 = 8'h77;
    repeat (2) tick();
    chk("t6.held", 32'(ov_a), 32'd1);
    rst_n = 1'b0;
    tick();
    chk("t6.out_valid", 32'(ov_a), 32'd0);
    chk("t6.out_data", 32'(od_a), 32'd0);
    chk("t6.pop_cnt", 32'(pc_a), 32'd0);
    chk("t6.state", 32'(st_a), 32'd0);
    chk("t6.err_sticky", 32'(es_a), 32'd0);
    rst_n = 1'b1;

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst_n   = ($urandom_range(0, 199) != 0);
      en      = ($urandom_range(0, 15) != 0);
      err_clr = ($urandom_range(0, 31) == 0);
      ordy    = ($urandom_range(0, 3) != 0);
      v1      = ($urandom_range(0, 3) != 0);
      v2      = ($urandom_range(0, 7) == 0) ? !v1 : v1;
      d1      = 8'($urandom);
      d2      = ($urandom_range(0, 15) == 0) ? (d1 ^ 8'(1 << $urandom_range(0, 7))) : d1;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_lockstep_reader.md
Name: fifo_lockstep_reader

Overview:
Read-side consumer for a pair of redundant FIFOs written in lockstep. It issues one common rd_en to both FIFOs, compares the two head words on every pop, and forwards the FIFO1 word downstream through a registered valid/ready stage. It detects data mismatches and valid skew between the pair, raises errors, and halts on fault if configured. It sits between the redundant FIFO pair and the downstream datapath.

Parameters:
DATA_WIDTH, 8, width of FIFO words and out_data
CNT_WIDTH, 8, width of mismatch_cnt (saturating) and pop_cnt (wrapping)
SKEW_MAX, 3, max consecutive cycles rd_valid_1 != rd_valid_2 tolerated; range 1..15
HALT_ON_MISMATCH, 1, 1 = data mismatch moves FSM to HALT; 0 = count and continue

Ports:
clk  input  1  clock, all logic on posedge
rst_n  input  1  synchronous active-low reset
en  input  1  enable reading (IDLE <-> RUN)
err_clr  input  1  clears err_sticky, skew_err and the skew counter; releases HALT
rd_valid_1  input  1  FIFO1 non-empty; rd_data_1 is valid head (first-word fall-through)
rd_data_1  input  DATA_WIDTH  FIFO1 head word
rd_valid_2  input  1  FIFO2 non-empty
rd_data_2  input  DATA_WIDTH  FIFO2 head word
rd_en  output  1  common pop to both FIFOs (combinational)
out_valid  output  1  downstream word valid (registered)
out_data  output  DATA_WIDTH  downstream word (registered)
out_ready  input  1  downstream accepts when out_valid && out_ready
mismatch  output  1  one-cycle pulse, cycle after a mismatching pop
err_sticky  output  1  set on any mismatch or skew fault; cleared only by err_clr or reset
skew_err  output  1  sticky valid-skew fault flag
mismatch_cnt  output  CNT_WIDTH  mismatching pops, saturates at all-ones
pop_cnt  output  CNT_WIDTH  total pops, wraps
state  output  2  FSM state: 0 IDLE, 1 RUN, 2 HALT

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE; out_valid=0, out_data=0, mismatch=0, err_sticky=0, skew_err=0, both counters=0, skew counter=0. Reset is honoured mid-transfer; a word held in the output register is discarded.
- rd_en = (state==RUN) && rd_valid_1 && rd_valid_2 && (!out_valid || out_ready). It is never asserted while either FIFO is empty, in IDLE, or in HALT.
- Pop (rd_en=1): out_data <= rd_data_1; out_valid <= 1; pop_cnt++. Latency is one cycle from pop to out_valid. Simultaneous downstream accept and pop keeps out_valid=1 with the new word, so throughput is 1 word/cycle.
- Accept without pop: out_valid <= 0. out_data holds while out_valid && !out_ready.
- Compare: on a pop with rd_data_1 != rd_data_2: mismatch=1 next cycle only; mismatch_cnt++ unless saturated; err_sticky <= 1. The FIFO1 word is still forwarded.
- Skew counter: in RUN, increments each cycle rd_valid_1 != rd_valid_2, resets to 0 when they are equal. When it reaches SKEW_MAX: skew_err <= 1, err_sticky <= 1, state <= HALT. The counter holds in IDLE/HALT.
- FSM transitions:
  - IDLE -> RUN when en=1.
  - RUN -> IDLE when en=0, and only at a cycle with no fault.
  - RUN -> HALT on skew fault, or on mismatch when HALT_ON_MISMATCH=1. Fault has priority over en=0.
  - HALT -> IDLE on err_clr=1.
  - err_clr in any state clears err_sticky, skew_err and the skew counter; counters are not cleared. If err_clr and a new fault occur in the same cycle, the fault wins: flags are set.
- The output register drains normally in IDLE and HALT; no new pops occur there.

Test Plan:
1. Reset, en=1, push 0x11, 0x22, 0x33 identically into both FIFOs, out_ready=1 -> three rd_en pulses on consecutive cycles; out_data 0x11/0x22/0x33 each one cycle after its pop; pop_cnt=3; mismatch never 1.
2. out_ready=0 with words available -> one pop, then rd_en=0 and out_data stable; raise out_ready -> pops resume back-to-back.
3. Head words FIFO1=0xA5, FIFO2=0xA4, HALT_ON_MISMATCH=1 -> out_data=0xA5, mismatch pulses 1 cycle, mismatch_cnt=1, err_sticky=1, state=HALT, rd_en=0; err_clr -> state=IDLE, err_sticky=0, mismatch_cnt stays 1.
4. rd_valid_1=1, rd_valid_2=0 for 3 cycles (SKEW_MAX=3) -> skew_err=1, state=HALT; a 2-cycle skew then re-alignment -> no fault.
5. HALT_ON_MISMATCH=0, 260 mismatching pops with CNT_WIDTH=8 -> mismatch_cnt saturates at 0xFF; pop_cnt=0x04 (wrapped).
6. rst_n=0 while out_valid=1 and out_ready=0 -> next cycle all outputs at reset values; state=IDLE.
